// File: rtl/mutex_lock_sequencer.sv
// mutex_lock_sequencer: round-robin local requesters acquire a shared Avalon-MM hardware mutex with read-back ownership check
module mutex_lock_sequencer #(
    parameter int          NUM_REQ    = 4,
    parameter logic [15:0] OWNER_BASE = 16'h0100,
    parameter logic [15:0] LOCK_VALUE = 16'h0001,
    parameter int          BACKOFF    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic [15:0]        fail_cnt,
    output logic               mtx_address,
    output logic               mtx_chipselect,
    output logic               mtx_write,
    output logic               mtx_read,
    output logic [31:0]        mtx_writedata,
    input  logic [31:0]        mtx_readdata
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_TRY_WR, S_CHECK_RD, S_BACKOFF, S_GRANTED, S_RELEASE
    } state_t;

    state_t        state, nxt;
    logic [IW-1:0] cur, rr_ptr, pick, k, nxt_ptr;
    logic          found, owned, drop;
    logic [7:0]    cnt;
    logic [15:0]   owner;

    assign owner       = OWNER_BASE + 16'(cur);
    assign owned       = mtx_readdata == {owner, LOCK_VALUE};
    assign nxt_ptr     = cur == IW'(NUM_REQ - 1) ? '0 : cur + 1'b1;
    assign drop        = !req[cur];
    assign busy        = state != S_IDLE;
    assign mtx_address = 1'b0;

    // first pending requester at or after the round-robin pointer, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(rr_ptr) + i >= NUM_REQ) ? IW'(int'(rr_ptr) + i - NUM_REQ) : IW'(int'(rr_ptr) + i);
            if (!found && req[k]) begin
                found = 1'b1;
                pick  = k;
            end
        end
    end

    // next state and Moore outputs: one bus strobe per state, grant only once ownership is read back
    always_comb begin
        nxt            = state;
        grant          = '0;
        mtx_chipselect = 1'b0;
        mtx_write      = 1'b0;
        mtx_read       = 1'b0;
        mtx_writedata  = '0;
        case (state)
            S_IDLE:     nxt = |req ? S_ARB : S_IDLE;
            S_ARB:      nxt = found ? S_TRY_WR : S_IDLE;
            S_TRY_WR: begin
                mtx_chipselect = 1'b1;
                mtx_write      = 1'b1;
                mtx_writedata  = {owner, LOCK_VALUE};
                nxt            = S_CHECK_RD;
            end
            S_CHECK_RD: begin
                mtx_chipselect = 1'b1;
                mtx_read       = 1'b1;
                nxt            = owned ? S_GRANTED : S_BACKOFF;
            end
            S_BACKOFF:  nxt = drop ? S_IDLE : (cnt == 8'd1 ? S_TRY_WR : S_BACKOFF);
            S_GRANTED: begin
                grant[cur] = 1'b1;
                nxt        = (rel[cur] || drop) ? S_RELEASE : S_GRANTED;
            end
            S_RELEASE: begin
                mtx_chipselect = 1'b1;
                mtx_write      = 1'b1;
                mtx_writedata  = {owner, 16'h0000};
                nxt            = S_IDLE;
            end
            default:    nxt = S_IDLE;
        endcase
    end

    // state register plus requester latch, backoff timer (exits as it would reach 0), failure count and RR pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cur      <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            fail_cnt <= '0;
        end else begin
            state <= nxt;
            if (state == S_ARB)
                cur <= pick;
            if (state == S_CHECK_RD && !owned) begin
                cnt      <= 8'(BACKOFF);
                fail_cnt <= fail_cnt + {15'd0, fail_cnt != 16'hFFFF};
            end
            if (state == S_BACKOFF)
                cnt <= cnt - 8'd1;
            if (state == S_RELEASE || (state == S_BACKOFF && drop))
                rr_ptr <= nxt_ptr;
        end
    end
endmodule

// File: tb/tb_mutex_lock_sequencer.sv
// tb_mutex_lock_sequencer: randomized scoreboard bench with a behavioural mutex and expected bus-event queue
`timescale 1ns/1ps
module tb_mutex_lock_sequencer;
    localparam int          N        = 4;
    localparam int          IW       = $clog2(N);
    localparam int          BO       = 8;
    localparam logic [15:0] OB       = 16'h0100;
    localparam logic [15:0] LV       = 16'h0001;
    localparam logic [31:0] CPU_WORD = 32'h0001_0001;

    logic         clk = 1'b0, reset_n = 1'b0;
    logic [N-1:0] req = '0, rel = '0, grant;
    logic         busy, mtx_address, mtx_chipselect, mtx_write, mtx_read;
    logic [15:0]  fail_cnt;
    logic [31:0]  mtx_writedata, mtx_readdata;

    mutex_lock_sequencer #(.NUM_REQ(N), .OWNER_BASE(OB), .LOCK_VALUE(LV), .BACKOFF(BO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .rel(rel), .grant(grant), .busy(busy),
        .fail_cnt(fail_cnt), .mtx_address(mtx_address), .mtx_chipselect(mtx_chipselect),
        .mtx_write(mtx_write), .mtx_read(mtx_read), .mtx_writedata(mtx_writedata),
        .mtx_readdata(mtx_readdata)
    );

    always #5 clk = ~clk;

    // behavioural mutex: a CPU holds it for the first reads up to deny_until, otherwise normal claim rules
    logic [31:0] mreg;
    int          rd_cnt = 0, deny_until = 0;
    wire         cpu_held = rd_cnt < deny_until;
    assign mtx_readdata = cpu_held ? CPU_WORD : mreg;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) mreg <= '0;
        else if (mtx_chipselect && mtx_write && !cpu_held &&
                 (mreg[15:0] == 16'h0 || mreg[31:16] == mtx_writedata[31:16])) mreg <= mtx_writedata;

    always @(posedge clk) if (mtx_chipselect && mtx_read) rd_cnt <= rd_cnt + 1;

    // scoreboard: kind 0 = grant change, 1 = write, 2 = read; gap = cycles since previous event, -1 = any
    typedef struct { int kind; logic [31:0] data; int gap; } ev_t;
    ev_t          exq[$];
    int           total = 0, bad = 0, cyc = 0, last_ev = 0;
    int           exp_fail = 0, rr = 0;
    logic [N-1:0] pg = '0;
    logic         pw = 1'b0, pr = 1'b0;

    task automatic expect_ev(int kind, logic [31:0] data, int gap);
        exq.push_back('{kind, data, gap});
    endtask

    task automatic see(int kind, logic [31:0] data);
        ev_t e;
        total++;
        if (exq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d data=%h, none expected", kind, data);
        end else begin
            e = exq.pop_front();
            if (e.kind != kind || e.data !== data || (e.gap >= 0 && cyc - last_ev != e.gap)) begin
                bad++;
                $display("FAIL bus_event: got kind=%0d data=%h gap=%0d, want kind=%0d data=%h gap=%0d",
                         kind, data, cyc - last_ev, e.kind, e.data, e.gap);
            end
        end
        last_ev = cyc;
    endtask

    // monitor: samples on the falling edge, checks bus rules and pops expected events
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!reset_n) begin
            pg = grant;
            pw = 1'b0;
            pr = 1'b0;
        end else begin
            total++;
            if ((mtx_write && mtx_read) || mtx_chipselect != (mtx_write || mtx_read) || mtx_address ||
                !$onehot0(grant) || (mtx_write && pw) || (mtx_read && pr)) begin
                bad++;
                $display("FAIL bus_rules: cs=%b wr=%b rd=%b addr=%b grant=%b", mtx_chipselect, mtx_write,
                         mtx_read, mtx_address, grant);
            end
            if (grant != pg) see(0, 32'(grant));
            if (mtx_write) see(1, mtx_writedata);
            if (mtx_read) see(2, 32'h0);
            pg = grant;
            pw = mtx_write;
            pr = mtx_read;
        end
    end

    task automatic finish_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic int winner(logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[IW'((rr + i) % N)]) return (rr + i) % N;
        return 0;
    endfunction

    function automatic logic [31:0] word(int w, logic [15:0] v);
        return {OB + 16'(w), v};
    endfunction

    task automatic wait_grant(int w);
        int n = 0;
        while (grant == '0 && n < 300) begin
            tick();
            n++;
        end
        check("grant_value", 32'(grant), 32'(1 << w));
        if (grant == '0) finish_up();
    endtask

    task automatic acquire(logic [N-1:0] mask, int nfail, output int w);
        w = winner(mask);
        deny_until = rd_cnt + nfail;
        for (int a = 0; a <= nfail; a++) begin
            expect_ev(1, word(w, LV), a == 0 ? -1 : BO + 1);
            expect_ev(2, 32'h0, 1);
        end
        expect_ev(0, 32'(1 << w), 1);
        exp_fail += nfail;
        req = mask;
        wait_grant(w);
    endtask

    task automatic release_grant(int w);
        int o = (w + 1 + int'($urandom_range(0, N - 2))) % N;
        int mode = int'($urandom_range(0, 2));
        rel = N'(1 << o);
        tick();
        rel = '0;
        repeat ($urandom_range(0, 3)) tick();
        check("grant_held", 32'(grant), 32'(1 << w));
        expect_ev(0, 32'h0, -1);
        expect_ev(1, word(w, 16'h0000), 0);
        if (mode != 1) rel = N'(1 << w);
        if (mode != 0) req = '0;
        tick();
        rel = '0;
        req = '0;
        repeat (3) tick();
        check("busy_idle", 32'(busy), 0);
        check("fail_cnt", 32'(fail_cnt), 32'(exp_fail));
        check("queue_drained", exq.size(), 0);
        rr = (w + 1) % N;
    endtask

    task automatic abandon(logic [N-1:0] mask);
        int w = winner(mask);
        int n = 0;
        deny_until = rd_cnt + 1000;
        expect_ev(1, word(w, LV), -1);
        expect_ev(2, 32'h0, 1);
        req = mask;
        while (fail_cnt == 16'(exp_fail) && n < 50) begin
            tick();
            n++;
        end
        exp_fail++;
        check("abandon_fail_cnt", 32'(fail_cnt), 32'(exp_fail));
        repeat ($urandom_range(0, 5)) tick();
        req = '0;
        repeat (3) tick();
        check("abandon_busy", 32'(busy), 0);
        check("abandon_fail_kept", 32'(fail_cnt), 32'(exp_fail));
        check("abandon_no_traffic", exq.size(), 0);
        rr = (w + 1) % N;
        deny_until = rd_cnt;
    endtask

    task automatic reset_mid(logic [N-1:0] mask);
        int w;
        acquire(mask, 0, w);
        tick();
        reset_n = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_strobes", {29'd0, mtx_chipselect, mtx_write, mtx_read}, 0);
        check("rst_fail_cnt", 32'(fail_cnt), 0);
        exp_fail = 0;
        rr = 0;
        tick();
        tick();
        w = winner(mask);
        expect_ev(1, word(w, LV), -1);
        expect_ev(2, 32'h0, 1);
        expect_ev(0, 32'(1 << w), 1);
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3) tick();
        check("latency_early", 32'(grant), 0);
        tick();
        check("latency_grant", 32'(grant), 32'(1 << w));
        release_grant(w);
    endtask

    initial begin
        int w;
        logic [N-1:0] m;
        repeat (3) tick();
        check("reset_grant", 32'(grant), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_fail_cnt", 32'(fail_cnt), 0);
        check("reset_strobes", {29'd0, mtx_chipselect, mtx_write, mtx_read}, 0);
        check("reset_wdata", mtx_writedata, 0);
        reset_n = 1'b1;
        tick();
        repeat (5) begin
            acquire(4'b1111, 0, w);
            release_grant(w);
        end
        acquire(4'b0001, 0, w);
        release_grant(w);
        acquire(4'b0100, 2, w);
        release_grant(w);
        abandon(4'b0010);
        acquire(4'b1111, 0, w);
        check("rr_after_abandon", w, 2);
        release_grant(w);
        repeat (20) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            if ($urandom_range(0, 4) == 0) abandon(m);
            else begin
                acquire(m, int'($urandom_range(0, 3)), w);
                release_grant(w);
            end
        end
        reset_mid(4'b1010);
        repeat (5) tick();
        check("final_queue", exq.size(), 0);
        finish_up();
    end
endmodule
